// File: rtl/cache_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_pkg
// Description : Shared types and constants for the I/D-cache main-memory
//               arbiter. It holds the FSM states, the owner encoding and the
//               default line geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_mem_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Which cache currently owns, or last owned, the memory port
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Default line geometry: 8 words of 4 bytes each
  localparam int LINE_WORDS_DEF = 8;
  localparam int BEAT_W_DEF     = $clog2(LINE_WORDS_DEF);
  localparam int OFFSET_W_DEF   = BEAT_W_DEF + 2;

  // Width of the beat counter for a given line size (at least one bit)
  function automatic int beat_width(input int line_words);
    beat_width = (line_words < 2) ? 1 : $clog2(line_words);
  endfunction

endpackage : cache_mem_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin picker. Bit 0 of req is the
//               I-cache and bit 1 is the D-cache. When both sides request,
//               the side that did not own the port last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import cache_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       valid,
  output owner_t     winner
);

  // Pick a winner. A lone requester always wins; on a tie, alternate.
  always_comb begin
    valid  = |req;
    winner = OWN_I;
    case (req)
      2'b01:   winner = OWN_I;
      2'b10:   winner = OWN_D;
      2'b11:   winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      default: winner = OWN_I;
    endcase
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one word-serial main-memory port between the I-cache
//               refill path and the D-cache refill/writeback path. It grants
//               one cache at a time in round-robin order, sequences the
//               line-sized burst one beat at a time, and pulses done when the
//               burst is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache refill port
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic              ic_done,
  // D-cache refill/writeback port
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic              dc_done,
  // Shared refill data
  output logic [DATA_W-1:0] rdata,
  // Main-memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W   = beat_width(LINE_WORDS);
  localparam int OFFSET_W = BEAT_W + 2;

  // Byte-offset bits inside a line; cleared to form the line base address
  localparam logic [ADDR_W-1:0] c_OFF_MASK =
    {{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};
  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic                arb_valid;
  owner_t              arb_winner;
  logic [ADDR_W-1:0]   sel_addr;

  rr_arb2 u_rr_arb2 (
    .req        ({dc_req, ic_req}),
    .last_owner (last_owner_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  // Address of the requester the picker chose
  assign sel_addr = (arb_winner == OWN_D) ? dc_addr : ic_addr;

  // Refill data goes straight from memory to both caches; rvalid qualifies it
  assign rdata = mem_rdata;

  // State register. Reset drops any burst in flight and hands the first tie
  // to the D-cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      base_q       <= '0;
      we_q         <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      base_q       <= base_d;
      we_q         <= we_d;
      beat_q       <= beat_d;
    end
  end

  // Next-state logic: select in IDLE, count acked beats in XFER, and record
  // the finished owner in DONE
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    base_d       = base_q;
    we_d         = we_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_winner;
          base_d  = sel_addr & ~c_OFF_MASK;
          we_d    = (arb_winner == OWN_D) && dc_we;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == c_LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. Everything is 0 outside XFER/DONE, so the outputs are
  // quiet in the cycle after reset.
  always_comb begin
    ic_gnt    = 1'b0;
    ic_rvalid = 1'b0;
    ic_done   = 1'b0;
    dc_gnt    = 1'b0;
    dc_rvalid = 1'b0;
    dc_done   = 1'b0;
    dc_wnext  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      XFER: begin
        ic_gnt    = (owner_q == OWN_I);
        dc_gnt    = (owner_q == OWN_D);
        mem_req   = 1'b1;
        mem_we    = we_q;
        // base is line-aligned, so this add never carries out of the line
        mem_addr  = base_q + ADDR_W'({beat_q, 2'b00});
        mem_wdata = dc_wdata;
        if (mem_ack) begin
          if (we_q) begin
            dc_wnext = 1'b1;
          end else if (owner_q == OWN_D) begin
            dc_rvalid = 1'b1;
          end else begin
            ic_rvalid = 1'b1;
          end
        end
      end
      DONE: begin
        ic_gnt  = (owner_q == OWN_I);
        dc_gnt  = (owner_q == OWN_D);
        ic_done = (owner_q == OWN_I);
        dc_done = (owner_q == OWN_D);
      end
      default: begin
      end
    endcase
  end

endmodule : cache_mem_arbiter
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed bench for cache_mem_arbiter. Each task drives one
//               scenario cycle by cycle and checks the outputs against
//               hand-computed values at the falling edge.
//               Status vector bit order: {ic_gnt, ic_rvalid, ic_done, dc_gnt,
//               dc_rvalid, dc_done, dc_wnext, mem_req, mem_we}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int LW = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  // Status encodings used by the expected-value tables
  localparam logic [8:0] c_ST_DC_RD  = 9'h032; // dc_gnt, dc_rvalid, mem_req
  localparam logic [8:0] c_ST_DC_DN  = 9'h028; // dc_gnt, dc_done
  localparam logic [8:0] c_ST_IC_RD  = 9'h182; // ic_gnt, ic_rvalid, mem_req
  localparam logic [8:0] c_ST_IC_DN  = 9'h140; // ic_gnt, ic_done
  localparam logic [8:0] c_ST_DC_WA  = 9'h027; // dc_gnt, wnext, mem_req, we
  localparam logic [8:0] c_ST_DC_WW  = 9'h023; // dc_gnt, mem_req, we (waiting)

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, ic_gnt, ic_rvalid, ic_done;
  logic [AW-1:0] ic_addr;
  logic          dc_req, dc_we, dc_wnext, dc_gnt, dc_rvalid, dc_done;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [8:0]    st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign st = {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done,
               dc_wnext, mem_req, mem_we};

  cache_mem_arbiter #(
    .LINE_WORDS (LW),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_gnt    (ic_gnt),
    .ic_rvalid (ic_rvalid),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_wnext  (dc_wnext),
    .dc_gnt    (dc_gnt),
    .dc_rvalid (dc_rvalid),
    .dc_done   (dc_done),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Outputs are quiet while in reset and after release; rdata passes through
  task automatic test_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    dc_wdata  = 32'hDEAD_BEEF;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (st !== 9'h000) begin
      bad++;
      $display("FAIL reset_status got=%h exp=%h", st, 9'h000);
    end
    total++;
    if (mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr, 32'h0);
    end
    total++;
    if (mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem_wdata got=%h exp=%h", mem_wdata, 32'h0);
    end
    total++;
    if (rdata !== 32'h5A5A_5A5A) begin
      bad++;
      $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h5A5A_5A5A);
    end
    @(posedge clk); #1;
    rst     = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (st !== 9'h000) begin
      bad++;
      $display("FAIL reset_idle_status got=%h exp=%h", st, 9'h000);
    end
  endtask

  // D-cache refill of line 0x1220 with memory acking every cycle
  task automatic test_dc_refill();
    logic [8:0]  exp_st;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        dc_req  = 1'b1;
        dc_addr = 32'h0000_1234;
        dc_we   = 1'b0;
        mem_ack = 1'b1;
      end
      if (c == 10) dc_req = 1'b0;
      exp_rd    = 32'hD000_0000 + 32'(c);
      mem_rdata = exp_rd;
      @(negedge clk);
      exp_st   = 9'h000;
      exp_addr = 32'h0;
      if (c >= 1 && c <= 8) begin
        exp_st   = c_ST_DC_RD;
        exp_addr = 32'h0000_1220 + 32'(4 * (c - 1));
      end else if (c == 9) begin
        exp_st = c_ST_DC_DN;
      end
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL refill_status c=%0d got=%h exp=%h", c, st, exp_st);
      end
      total++;
      if (mem_addr !== exp_addr) begin
        bad++;
        $display("FAIL refill_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr);
      end
      total++;
      if (rdata !== exp_rd) begin
        bad++;
        $display("FAIL refill_rdata c=%0d got=%h exp=%h", c, rdata, exp_rd);
      end
    end
    mem_ack = 1'b0;
  endtask

  // Simultaneous requests after reset: D first, then I, then a third D request
  task automatic test_simultaneous();
    logic [8:0]  exp_st;
    logic [31:0] exp_addr;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        rst     = 1'b0;
        ic_req  = 1'b1;
        ic_addr = 32'h0000_4018;
        dc_req  = 1'b1;
        dc_addr = 32'h0000_0A5C;
        dc_we   = 1'b0;
        mem_ack = 1'b1;
      end
      if (c == 10) dc_req = 1'b0;
      if (c == 12) begin
        dc_req  = 1'b1;
        dc_addr = 32'h0000_2000;
      end
      if (c == 20) ic_req = 1'b0;
      if (c == 30) dc_req = 1'b0;
      @(negedge clk);
      exp_st   = 9'h000;
      exp_addr = 32'h0;
      if (c >= 1 && c <= 8) begin
        exp_st   = c_ST_DC_RD;
        exp_addr = 32'h0000_0A40 + 32'(4 * (c - 1));
      end else if (c == 9) begin
        exp_st = c_ST_DC_DN;
      end else if (c >= 11 && c <= 18) begin
        exp_st   = c_ST_IC_RD;
        exp_addr = 32'h0000_4000 + 32'(4 * (c - 11));
      end else if (c == 19) begin
        exp_st = c_ST_IC_DN;
      end else if (c >= 21 && c <= 28) begin
        exp_st   = c_ST_DC_RD;
        exp_addr = 32'h0000_2000 + 32'(4 * (c - 21));
      end else if (c == 29) begin
        exp_st = c_ST_DC_DN;
      end
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL simul_status c=%0d got=%h exp=%h", c, st, exp_st);
      end
      total++;
      if (mem_addr !== exp_addr) begin
        bad++;
        $display("FAIL simul_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr);
      end
    end
    mem_ack = 1'b0;
  endtask

  // D-cache writeback with memory acking every second cycle
  task automatic test_writeback_wait();
    logic [8:0]  exp_st;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    for (int c = 0; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        dc_req  = 1'b1;
        dc_we   = 1'b1;
        dc_addr = 32'h0000_3300;
      end
      mem_ack  = (c >= 2 && c <= 16 && (c % 2) == 0);
      dc_wdata = (c >= 1 && c <= 16) ? 32'h0000_00A0 + 32'((c - 1) / 2)
                                     : 32'h0000_00A0;
      if (c == 18) begin
        dc_req = 1'b0;
        dc_we  = 1'b0;
      end
      @(negedge clk);
      exp_st   = 9'h000;
      exp_addr = 32'h0;
      exp_wd   = 32'h0;
      if (c >= 1 && c <= 16) begin
        exp_st   = ((c % 2) == 0) ? c_ST_DC_WA : c_ST_DC_WW;
        exp_addr = 32'h0000_3300 + 32'(4 * ((c - 1) / 2));
        exp_wd   = 32'h0000_00A0 + 32'((c - 1) / 2);
      end else if (c == 17) begin
        exp_st = c_ST_DC_DN;
      end
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL wb_status c=%0d got=%h exp=%h", c, st, exp_st);
      end
      total++;
      if (mem_addr !== exp_addr) begin
        bad++;
        $display("FAIL wb_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr);
      end
      total++;
      if (mem_wdata !== exp_wd) begin
        bad++;
        $display("FAIL wb_wdata c=%0d got=%h exp=%h", c, mem_wdata, exp_wd);
      end
    end
    mem_ack = 1'b0;
  endtask

  // Reset during an I-cache refill: no done, and D wins the tie afterwards
  task automatic test_reset_mid_burst();
    logic [8:0]  exp_st;
    logic [31:0] exp_addr;
    for (int c = 0; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        ic_req  = 1'b1;
        ic_addr = 32'h0000_5000;
        mem_ack = 1'b1;
      end
      if (c == 4) begin
        rst     = 1'b1;
        dc_req  = 1'b1;
        dc_addr = 32'h0000_6000;
        dc_we   = 1'b0;
      end
      if (c == 5)  rst    = 1'b0;
      if (c == 15) dc_req = 1'b0;
      if (c == 25) ic_req = 1'b0;
      @(negedge clk);
      exp_st   = 9'h000;
      exp_addr = 32'h0;
      if (c >= 1 && c <= 4) begin
        exp_st   = c_ST_IC_RD;
        exp_addr = 32'h0000_5000 + 32'(4 * (c - 1));
      end else if (c >= 6 && c <= 13) begin
        exp_st   = c_ST_DC_RD;
        exp_addr = 32'h0000_6000 + 32'(4 * (c - 6));
      end else if (c == 14) begin
        exp_st = c_ST_DC_DN;
      end else if (c >= 16 && c <= 23) begin
        exp_st   = c_ST_IC_RD;
        exp_addr = 32'h0000_5000 + 32'(4 * (c - 16));
      end else if (c == 24) begin
        exp_st = c_ST_IC_DN;
      end
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL rstmid_status c=%0d got=%h exp=%h", c, st, exp_st);
      end
      total++;
      if (mem_addr !== exp_addr) begin
        bad++;
        $display("FAIL rstmid_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr);
      end
    end
    mem_ack = 1'b0;
  endtask

  // Stray acks in IDLE are ignored; the owner drops req at beat 2 mid-burst
  task automatic test_drop_and_stray();
    logic [8:0]  exp_st;
    logic [31:0] exp_addr;
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 0) mem_ack = 1'b1;
      if (c == 2) begin
        dc_req  = 1'b1;
        dc_addr = 32'h0000_7010;
        dc_we   = 1'b0;
      end
      if (c == 5) dc_req = 1'b0;
      @(negedge clk);
      exp_st   = 9'h000;
      exp_addr = 32'h0;
      if (c >= 3 && c <= 10) begin
        exp_st   = c_ST_DC_RD;
        exp_addr = 32'h0000_7000 + 32'(4 * (c - 3));
      end else if (c == 11) begin
        exp_st = c_ST_DC_DN;
      end
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL drop_status c=%0d got=%h exp=%h", c, st, exp_st);
      end
      total++;
      if (mem_addr !== exp_addr) begin
        bad++;
        $display("FAIL drop_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ic_req    = 1'b0;
    ic_addr   = 32'h0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = 32'h0;
    dc_wdata  = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_dc_refill();
    test_simultaneous();
    test_writeback_wait();
    test_reset_mid_burst();
    test_drop_and_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cache_mem_arbiter
`default_nettype wire

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single word-serial main-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the RV32 pipelined core. Each cache raises a line-sized burst request on a miss. The arbiter grants one requester at a time using round-robin, sequences the burst beat by beat, and returns a `done` pulse. The caches use that pulse to release their miss stall into the hazard unit.

## Interface
Parameters:
- `LINE_WORDS`, 8: words per cache line; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width.

Ports:
- `clk`  in  1  core clock; the block uses this single clock.
- `rst`  in  1  synchronous, active-high reset.
- `ic_req`  in  1  I-cache line refill request; held high until `ic_done`.
- `ic_addr`  in  ADDR_W  I-cache line address; stable while `ic_req` is high.
- `ic_gnt`  out  1  I-cache owns the memory port.
- `ic_rvalid`  out  1  `rdata` holds the current I-cache refill word.
- `ic_done`  out  1  one-cycle pulse: I-cache burst complete.
- `dc_req`  in  1  D-cache burst request; held high until `dc_done`.
- `dc_we`  in  1  1 = writeback burst, 0 = refill burst; stable while `dc_req` is high.
- `dc_addr`  in  ADDR_W  D-cache line address.
- `dc_wdata`  in  DATA_W  writeback word for the current beat.
- `dc_wnext`  out  1  pulse: current write word accepted; present the next word on the following cycle.
- `dc_gnt`  out  1  D-cache owns the memory port.
- `dc_rvalid`  out  1  `rdata` holds the current D-cache refill word.
- `dc_done`  out  1  one-cycle pulse: D-cache burst complete.
- `rdata`  out  DATA_W  shared refill data; a direct pass-through of `mem_rdata`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  word byte-address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_ack`  in  1  memory completed the current word; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_W  read data.

## Operation
- FSM has three states: IDLE, XFER and DONE.
- **IDLE**
  - With no request pending, stay in IDLE.
  - With exactly one request pending, select that requester.
  - With both requests pending, select the requester opposite `last_owner`.
  - On selection, latch `owner`, `base` and `we`, clear `beat`, and go to XFER.
  - `base` is the request address with bits [log2(LINE_WORDS)+1:0] forced to 0.
  - `we` = `dc_we` for the D-cache and 0 for the I-cache.
- **XFER**
  - Outputs: `mem_req` = 1, `mem_we` = `we`, `mem_addr` = `base` + 4·`beat`, `mem_wdata` = `dc_wdata`.
  - On `mem_ack`, a read asserts the owner's `rvalid` in the same cycle; a write asserts `dc_wnext` in the same cycle.
  - On `mem_ack`, `beat` increments.
  - On `mem_ack` with `beat` == LINE_WORDS−1, go to DONE.
- **DONE**
  - `mem_req` = 0; pulse the owner's `done`.
  - Set `last_owner` = `owner`; go to IDLE.
- `ic_gnt`/`dc_gnt` are high for the owner during XFER and DONE; otherwise 0.
- The `beat` counter is log2(LINE_WORDS) bits wide. The address add never carries out of the line because `base` is line-aligned.
- **Boundary conditions:**
  - A requester that drops `req` mid-burst does not stop the burst; it completes and `done` still pulses.
  - A `req` still high in the cycle after `done` is treated as a new request in IDLE.
  - `mem_ack` is ignored outside XFER.
  - A request arriving during another requester's burst waits. It wins the next IDLE because `last_owner` alternates, so neither side starves.
  - Reset mid-burst abandons the burst with no `done`. The memory must tolerate `mem_req` dropping before `mem_ack`.

## Timing
- **Reset:** state IDLE, `last_owner` = I-cache, so the D-cache wins a simultaneous first request. Every output reads 0 in the cycle after the reset edge. `rdata` follows `mem_rdata` combinationally and is exempt.
- **Request to first beat:** a request seen in IDLE at cycle 0 drives `mem_req` from cycle 1.
- **Minimum burst (`mem_ack` every cycle):** beats occupy cycles 1..LINE_WORDS, `done` pulses at LINE_WORDS+1, and the next grant's XFER starts at LINE_WORDS+3.
- **Memory handshake:** `mem_addr`/`mem_we`/`mem_wdata` stay stable from `mem_req` rise until `mem_ack`. The next beat's address appears in the cycle after the ack with `mem_req` still high.
- **Write data:** after a `dc_wnext` pulse, the D-cache presents the next `dc_wdata` on the following cycle.
- Variable memory latency only stretches XFER; there is no timeout.

## Structure
- Package `cache_mem_pkg`:
  - FSM state enum {IDLE, XFER, DONE};
  - owner encoding (OWN_I = 0, OWN_D = 1);
  - default LINE_WORDS and the derived offset/beat widths.
- Sub-module `rr_arb2`: a combinational two-way round-robin picker. It takes `req[1:0]` and `last_owner` and returns `valid` and `winner`. Keeping it separate allows it to be reused for a future uncached-port arbiter.

## Test plan
- **D-cache refill, 0-wait memory:** `dc_req` = 1, `dc_addr` = 0x0000_1234, `dc_we` = 0, `mem_ack` tied high.
  - `mem_addr` = 0x1220, 0x1224, …, 0x123C in cycles 1–8.
  - Eight `dc_rvalid` pulses; `dc_done` at cycle 9; `ic_*` outputs stay 0.
- **Simultaneous requests after reset:** `ic_req` and `dc_req` rise together.
  - The D-cache burst runs first; the I-cache XFER begins at cycle 11.
  - A third back-to-back D-cache request is then served only after the I-cache burst.
- **D-cache writeback, 2-cycle memory latency:** `mem_ack` every 2nd cycle.
  - `mem_we` = 1 for all beats.
  - `dc_wnext` coincides with each `mem_ack`; `mem_wdata` tracks the pattern 0xA0..0xA7.
  - `dc_done` at cycle 17.
- **Reset at beat 3 of an I-cache refill:** `mem_req`, `ic_gnt` and `ic_rvalid` are 0 in the cycle after the reset edge, with no `ic_done`. A fresh `dc_req` afterwards wins.
- **Owner drops `req` at beat 2; stray `mem_ack` in IDLE:** the burst still completes all eight beats and pulses `done`. The stray `mem_ack` produces no `rvalid` and no state change.
